// File: rtl/imm_extend_pipe.sv
// Immediate extension stage with a 2-entry in-order output buffer.
// The extended result is computed combinationally from in_imm/in_mode and the
// result (not the raw field) is what gets buffered. in_ready depends only on
// registered occupancy, so there is no combinational path from out_ready.
module imm_extend_pipe #(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_imm,
  input  logic [1:0]           in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic [1:0]           occupancy
);

  // Branch mode shifts the sign-extended value left by two, so two spare
  // bits above the field are the minimum that keeps its sign meaningful.
  if (OUT_WIDTH < IN_WIDTH + 2) begin : g_width_check
    $error("imm_extend_pipe: OUT_WIDTH must be at least IN_WIDTH+2");
  end

  localparam int unsigned ExtWidth = OUT_WIDTH - IN_WIDTH;

  typedef enum logic [1:0] {
    ModeSign   = 2'b00,
    ModeZero   = 2'b01,
    ModeUpper  = 2'b10,
    ModeBranch = 2'b11
  } mode_e;

  logic [OUT_WIDTH-1:0] sext;
  logic [OUT_WIDTH-1:0] zext;
  logic [OUT_WIDTH-1:0] upper;
  logic [OUT_WIDTH-1:0] branch;
  logic [OUT_WIDTH-1:0] ext_res;

  logic [OUT_WIDTH-1:0] slot0_q, slot0_d;  // head entry, drives out_data
  logic [OUT_WIDTH-1:0] slot1_q, slot1_d;  // second entry, valid only at count 2
  logic [1:0]           count_q, count_d;

  logic push;
  logic pop;

  // Handshake outputs come from registered state only.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = slot0_q;
  assign occupancy = count_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Extension candidates for each mode.
  always_comb begin
    sext   = {{ExtWidth{in_imm[IN_WIDTH-1]}}, in_imm};
    zext   = {{ExtWidth{1'b0}}, in_imm};
    upper  = {in_imm, {ExtWidth{1'b0}}};
    branch = {sext[OUT_WIDTH-3:0], 2'b00};
  end

  // Mode select for the value to be buffered.
  always_comb begin
    ext_res = sext;
    case (mode_e'(in_mode))
      ModeSign:   ext_res = sext;
      ModeZero:   ext_res = zext;
      ModeUpper:  ext_res = upper;
      ModeBranch: ext_res = branch;
      default:    ext_res = sext;
    endcase
  end

  // Buffer next state: the head always lives in slot0, so a retire shifts
  // slot1 forward and a concurrent accept at count 1 lands directly in slot0.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          slot0_d = ext_res;
        end else begin
          slot1_d = ext_res;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Only reachable at count 1: push needs count < 2, pop needs count > 0.
        slot0_d = ext_res;
      end
      default: begin
      end
    endcase
  end

  // State registers; reset wins over any accept or retire on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: table-driven mode vectors, a
// scoreboard on the default instance, and directed multi-cycle sequences.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  occupancy;

  logic        n_in_valid;
  logic        n_in_ready;
  logic [7:0]  n_in_imm;
  logic [1:0]  n_in_mode;
  logic        n_out_valid;
  logic        n_out_ready;
  logic [15:0] n_out_data;
  logic [1:0]  n_occupancy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_next;

  typedef struct {
    logic [15:0] imm;
    logic [1:0]  mode;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [7:0]  imm;
    logic [1:0]  mode;
    logic [15:0] exp;
  } nvec_t;

  vec_t  vecs[6];
  nvec_t nvecs[3];

  always #5 clk = ~clk;

  imm_extend_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  imm_extend_pipe #(
    .IN_WIDTH  (8),
    .OUT_WIDTH (16)
  ) dut_n (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (n_in_valid),
    .in_ready  (n_in_ready),
    .in_imm    (n_in_imm),
    .in_mode   (n_in_mode),
    .out_valid (n_out_valid),
    .out_ready (n_out_ready),
    .out_data  (n_out_data),
    .occupancy (n_occupancy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] imm, input logic [1:0] mode,
                       input logic [31:0] exp);
    in_valid = v;
    in_imm   = imm;
    in_mode  = mode;
    exp_next = exp;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (sb.size() != 0 && k < 20) begin
      tick();
      k++;
    end
    check(name, sb.size(), 0);
  endtask

  // Scoreboard: handshakes are evaluated mid-cycle, ahead of the edge that
  // commits them; reset on that edge discards everything in flight.
  always @(negedge clk) begin
    logic [31:0] exp_v;
    if (reset) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: got 0x%08h, required no output at %0t", out_data, $time);
        end else begin
          exp_v = sb.pop_front();
          check("sb_data", out_data, exp_v);
        end
      end
      if (in_valid && in_ready) sb.push_back(exp_next);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{imm: 16'hFFFF, mode: 2'b00, exp: 32'hFFFF_FFFF};
    vecs[1] = '{imm: 16'h7FFF, mode: 2'b00, exp: 32'h0000_7FFF};
    vecs[2] = '{imm: 16'hFFFF, mode: 2'b01, exp: 32'h0000_FFFF};
    vecs[3] = '{imm: 16'h1234, mode: 2'b10, exp: 32'h1234_0000};
    vecs[4] = '{imm: 16'h8000, mode: 2'b11, exp: 32'hFFFE_0000};
    vecs[5] = '{imm: 16'h0001, mode: 2'b11, exp: 32'h0000_0004};
    nvecs[0] = '{imm: 8'h80, mode: 2'b00, exp: 16'hFF80};
    nvecs[1] = '{imm: 8'hAB, mode: 2'b10, exp: 16'hAB00};
    nvecs[2] = '{imm: 8'h7F, mode: 2'b11, exp: 16'h01FC};

    reset       = 1'b1;
    out_ready   = 1'b0;
    drive(1'b0, 16'h0, 2'b00, 32'h0);
    n_in_valid  = 1'b0;
    n_in_imm    = 8'h0;
    n_in_mode   = 2'b00;
    n_out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_occupancy", occupancy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_n_out_valid", n_out_valid, 0);

    // Mode table, one entry at a time: result one cycle after accept
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, vecs[i].imm, vecs[i].mode, vecs[i].exp);
      @(negedge clk);
      tick();
      drive(1'b0, 16'h0, 2'b00, 32'h0);
      @(negedge clk);
      check($sformatf("mode%0d_valid", i), out_valid, 1);
      check($sformatf("mode%0d_data", i), out_data, vecs[i].exp);
      tick();
    end

    // Streaming: 8 back-to-back entries, steady occupancy 1
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) drive(1'b1, 16'(i), 2'b00, 32'(i));
      else drive(1'b0, 16'h0, 2'b00, 32'h0);
      @(negedge clk);
      if (i < 8) check($sformatf("stream%0d_in_ready", i), in_ready, 1);
      if (i > 0) begin
        check($sformatf("stream%0d_out_valid", i), out_valid, 1);
        check($sformatf("stream%0d_occupancy", i), occupancy, 1);
      end
      tick();
    end
    drain("stream_drain");

    // Backpressure: third offer held until a slot frees
    out_ready = 1'b0;
    drive(1'b1, 16'h0001, 2'b01, 32'h0000_0001);
    @(negedge clk);
    check("bp_in_ready0", in_ready, 1);
    tick();
    drive(1'b1, 16'h0002, 2'b01, 32'h0000_0002);
    @(negedge clk);
    check("bp_occupancy1", occupancy, 1);
    tick();
    drive(1'b1, 16'h0003, 2'b01, 32'h0000_0003);
    @(negedge clk);
    check("bp_occupancy2", occupancy, 2);
    check("bp_in_ready_full", in_ready, 0);
    check("bp_head", out_data, 32'h0000_0001);
    tick();
    @(negedge clk);
    check("bp_hold_occupancy", occupancy, 2);
    check("bp_hold_data", out_data, 32'h0000_0001);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", in_ready, 0);
    tick();
    @(negedge clk);
    check("bp_after_retire_in_ready", in_ready, 1);
    check("bp_after_retire_occupancy", occupancy, 1);
    tick();
    drive(1'b0, 16'h0, 2'b00, 32'h0);
    drain("bp_drain");

    // Simultaneous accept and retire at occupancy 1
    out_ready = 1'b0;
    drive(1'b1, 16'h0011, 2'b00, 32'h0000_0011);
    @(negedge clk);
    tick();
    drive(1'b1, 16'h00AB, 2'b10, 32'h00AB_0000);
    out_ready = 1'b1;
    @(negedge clk);
    check("simul_occupancy_before", occupancy, 1);
    tick();
    drive(1'b0, 16'h0, 2'b00, 32'h0);
    @(negedge clk);
    check("simul_occupancy_after", occupancy, 1);
    check("simul_second", out_data, 32'h00AB_0000);
    tick();
    drain("simul_drain");

    // Reset at occupancy 2 with an offer pending
    out_ready = 1'b0;
    drive(1'b1, 16'h0005, 2'b01, 32'h0000_0005);
    tick();
    drive(1'b1, 16'h0006, 2'b01, 32'h0000_0006);
    @(negedge clk);
    tick();
    drive(1'b1, 16'h0007, 2'b01, 32'h0000_0007);
    @(negedge clk);
    check("rst2_occupancy_before", occupancy, 2);
    tick();
    reset = 1'b1;
    @(negedge clk);
    tick();
    reset = 1'b0;
    drive(1'b0, 16'h0, 2'b00, 32'h0);
    @(negedge clk);
    check("rst2_occupancy", occupancy, 0);
    check("rst2_out_valid", out_valid, 0);
    check("rst2_out_data", out_data, 0);
    check("rst2_in_ready", in_ready, 1);

    // Reset at occupancy 1 while in_ready is high: the offer is still dropped
    tick();
    drive(1'b1, 16'h0009, 2'b01, 32'h0000_0009);
    tick();
    reset = 1'b1;
    drive(1'b1, 16'h000A, 2'b01, 32'h0000_000A);
    @(negedge clk);
    tick();
    reset = 1'b0;
    drive(1'b0, 16'h0, 2'b00, 32'h0);
    out_ready = 1'b1;
    @(negedge clk);
    check("rst1_occupancy", occupancy, 0);
    tick();
    @(negedge clk);
    check("rst1_no_output", out_valid, 0);
    tick();

    // Parameter override instance
    n_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_in_valid = 1'b1;
      n_in_imm   = nvecs[i].imm;
      n_in_mode  = nvecs[i].mode;
      @(negedge clk);
      tick();
      n_in_valid = 1'b0;
      @(negedge clk);
      check($sformatf("narrow%0d_valid", i), n_out_valid, 1);
      check($sformatf("narrow%0d_data", i), n_out_data, nvecs[i].exp);
      tick();
    end

    check("final_sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
